// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction-fetch sequencer.
//   XLEN          : architectural PC / instruction width
//   PC_STEP       : byte distance between sequential fetches
//   RESET_PC_DEF  : default first fetch address after reset
//   QUEUE_DEPTH   : number of entries in the fetch buffer
//   fetch_entry_t : one buffered fetch {pc, inst}
// -----------------------------------------------------------------------------
package fetch_pkg;

   localparam int              XLEN         = 32;
   localparam logic [XLEN-1:0] PC_STEP      = 32'd4;
   localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [1:0]      QUEUE_DEPTH  = 2'd2;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } fetch_entry_t;

endpackage : fetch_pkg

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Two-entry FIFO of fetch_entry_t. entry0 is always the head, so the head
// outputs come straight from flops.
//   clk, rst_n  : clock, synchronous active-low reset
//   flush       : drop all buffered entries (takes priority over push/pop)
//   push        : write push_entry at the tail
//   push_entry  : entry to write
//   pop         : remove the head (ignored when empty)
//   head        : current head entry (registered)
//   count       : number of valid entries, 0..2
// -----------------------------------------------------------------------------
module fetch_queue
   import fetch_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  fetch_entry_t push_entry,
   input  logic         pop,
   output fetch_entry_t head,
   output logic [1:0]   count
);

   fetch_entry_t entry0;
   fetch_entry_t entry1;
   logic [1:0]   count_q;
   logic         pop_ok;

   assign pop_ok = pop && (count_q != 2'd0);

   always_ff @(posedge clk) begin
      // NOTE: the storage is reset too, because the head is visible on the
      // outputs and must read as zero straight after reset.
      if (!rst_n) begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         entry0  <= '0;
         entry1  <= '0;
         count_q <= '0;
      end else if (flush) begin
         count_q <= '0;
      end else begin
         case ({push, pop_ok})
            2'b10: begin
               if (count_q != QUEUE_DEPTH) begin
                  if (count_q == 2'd0) entry0 <= push_entry;
                  else                 entry1 <= push_entry;
                  count_q <= count_q + 2'd1;
               end
            end
            2'b01: begin
               entry0  <= entry1;
               count_q <= count_q - 2'd1;
            end
            2'b11: begin
               // Count unchanged: new entry lands behind whatever remains.
               if (count_q == 2'd1) begin
                  entry0 <= push_entry;
               end else begin
                  entry0 <= entry1;
                  entry1 <= push_entry;
               end
            end
            default: ;
         endcase
      end
   end

   assign head  = entry0;
   assign count = count_q;

endmodule : fetch_queue

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Instruction-fetch sequencer between a registered (1-cycle latency) ROM and
// decode. Issues fetch PCs, tracks the request in flight, buffers results in
// a 2-entry queue and restarts at redirect targets.
// Optional feature macro: FETCH_PERF_CNT_EN enables the fetch/redirect
// performance counters; without it both counters read 0.
//   clk, rst_n     : clock, synchronous active-low reset
//   rom_pc         : ROM address (ROM returns data the following cycle)
//   rom_inst       : ROM data for the address issued last cycle
//   redirect_valid : flush and restart at redirect_pc
//   redirect_pc    : restart target, low two bits ignored
//   out_valid      : head instruction available (registered)
//   out_ready      : decode accepts the head this cycle
//   out_inst       : head instruction (registered)
//   out_pc         : head PC (registered)
//   fetch_cnt      : instructions accepted by decode
//   redirect_cnt   : redirect cycles seen
// DATA_WIDTH must match fetch_pkg::XLEN.
// -----------------------------------------------------------------------------
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int                    DATA_WIDTH = XLEN,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = RESET_PC_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic [DATA_WIDTH-1:0] rom_pc,
   input  logic [DATA_WIDTH-1:0] rom_inst,
   input  logic                  redirect_valid,
   input  logic [DATA_WIDTH-1:0] redirect_pc,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_inst,
   output logic [DATA_WIDTH-1:0] out_pc,
   output logic [31:0]           fetch_cnt,
   output logic [31:0]           redirect_cnt
);

   logic [DATA_WIDTH-1:0] pc_q;
   logic                  issued_q;
   logic [DATA_WIDTH-1:0] issued_pc_q;

   logic                  issue;
   logic                  pop;
   logic                  push;
   logic [1:0]            occupancy;
   logic [1:0]            count;
   fetch_entry_t          head;
   fetch_entry_t          push_entry;
   logic                  unused_bits;

   // Word alignment discards the low target bits.
   assign unused_bits = &{1'b0, redirect_pc[1:0]};

   assign pop = out_valid & out_ready;

   always_comb begin
      // NOTE: defaults first so every path assigns every signal (no latches).
      rom_pc = pc_q;
      if (redirect_valid) rom_pc = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
      // Credits: buffered + in flight - leaving must stay below the depth,
      // so a request's result always has a slot when it returns.
      occupancy = count + {1'b0, issued_q} - {1'b0, pop};
      issue     = redirect_valid | (occupancy < QUEUE_DEPTH);
   end

   // A result returning in a redirect cycle belongs to the squashed stream.
   assign push            = issued_q & ~redirect_valid;
   assign push_entry.pc   = issued_pc_q;
   assign push_entry.inst = rom_inst;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q        <= RESET_PC;
         issued_q    <= 1'b0;
         issued_pc_q <= '0;
      end else if (issue) begin
         issued_q    <= 1'b1;
         issued_pc_q <= rom_pc;
         pc_q        <= rom_pc + PC_STEP;
      end else begin
         issued_q    <= 1'b0;
      end
   end

   fetch_queue u_queue (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (redirect_valid),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .head       (head),
      .count      (count)
   );

   assign out_valid = (count != 2'd0);
   assign out_inst  = head.inst;
   assign out_pc    = head.pc;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt_q;
   logic [31:0] redirect_cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_cnt_q    <= '0;
         redirect_cnt_q <= '0;
      end else begin
         // A pop in a redirect cycle was still consumed by decode.
         if (pop)            fetch_cnt_q    <= fetch_cnt_q + 32'd1;
         if (redirect_valid) redirect_cnt_q <= redirect_cnt_q + 32'd1;
      end
   end

   assign fetch_cnt    = fetch_cnt_q;
   assign redirect_cnt = redirect_cnt_q;
`else
   assign fetch_cnt    = '0;
   assign redirect_cnt = '0;
`endif

endmodule : fetch_ctrl

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
// Directed bench for fetch_ctrl with a registered ROM model. Inputs change and
// outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] rom_pc;
   logic [31:0] rom_inst = '0;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic [31:0] fetch_cnt;
   logic [31:0] redirect_cnt;

   int checks = 0;
   int errors = 0;

`ifdef FETCH_PERF_CNT_EN
   localparam logic [31:0] EXP_FETCH_CNT    = 32'd10;
   localparam logic [31:0] EXP_REDIRECT_CNT = 32'd2;
`else
   localparam logic [31:0] EXP_FETCH_CNT    = 32'd0;
   localparam logic [31:0] EXP_REDIRECT_CNT = 32'd0;
`endif

   always #5 clk = ~clk;

   fetch_ctrl #(
      .DATA_WIDTH (32),
      .RESET_PC   (32'h0000_0000)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .rom_pc         (rom_pc),
      .rom_inst       (rom_inst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_inst       (out_inst),
      .out_pc         (out_pc),
      .fetch_cnt      (fetch_cnt),
      .redirect_cnt   (redirect_cnt)
   );

   // Program image: a few real words, everything else address-derived.
   function automatic logic [31:0] rom_word(input logic [31:0] addr);
      case (addr)
         32'h0000_0000: rom_word = 32'hE400_FFFF;
         32'h0000_0004: rom_word = 32'hE800_FFFF;
         32'h0000_003C: rom_word = 32'hCC00_0001;
         default:       rom_word = addr ^ 32'h5A5A_0000;
      endcase
   endfunction

   always @(posedge clk) rom_inst <= rom_word(rom_pc);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check_head(input string tag, input logic [31:0] pc);
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_pc"}, out_pc, pc);
      check({tag, "_inst"}, out_inst, rom_word(pc));
   endtask

   initial begin
      rst_n          = 1'b0;
      out_ready      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      tick();
      tick();

      // Reset state
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_inst", out_inst, 32'd0);
      check("rst_pc", out_pc, 32'd0);
      check("rst_fcnt", fetch_cnt, 32'd0);
      check("rst_rcnt", redirect_cnt, 32'd0);
      check("rst_rompc", rom_pc, 32'd0);

      // Streaming from reset with decode always ready
      rst_n     = 1'b1;
      out_ready = 1'b1;
      tick();
      check("s_gap", 32'(out_valid), 32'd0);
      tick();
      check_head("s0", 32'h0);
      check("s0_word", out_inst, 32'hE400_FFFF);
      tick();
      check_head("s1", 32'h4);
      check("s1_word", out_inst, 32'hE800_FFFF);
      tick();
      check_head("s2", 32'h8);

      // Stall: decode not ready for 5 cycles from first valid
      rst_n     = 1'b0;
      out_ready = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      check("st_gap", 32'(out_valid), 32'd0);
      tick();
      check_head("st_hold0", 32'h0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check_head("st_hold", 32'h0);
         check("st_rompc", rom_pc, 32'h8);
      end
      out_ready = 1'b1;
      tick();
      check_head("st_rel1", 32'h4);
      tick();
      check_head("st_rel2", 32'h8);
      tick();
      check_head("st_rel3", 32'hC);

      // Redirect to 0x3C, coinciding with a pop of 0xC
      redirect_valid = 1'b1;
      redirect_pc    = 32'h3C;
      #1;
      check("rd_rompc", rom_pc, 32'h3C);
      tick();
      redirect_valid = 1'b0;
      check("rd_bubble", 32'(out_valid), 32'd0);
      tick();
      check_head("rd_tgt", 32'h3C);
      check("rd_word", out_inst, 32'hCC00_0001);
      tick();
      check_head("rd_next", 32'h40);

      // Misaligned target is forced to word alignment
      redirect_valid = 1'b1;
      redirect_pc    = 32'h2E;
      #1;
      check("al_rompc", rom_pc, 32'h2C);
      tick();
      redirect_valid = 1'b0;
      check("al_bubble", 32'(out_valid), 32'd0);
      tick();
      check_head("al_tgt", 32'h2C);

      // PC wrap at the top of the address space
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      check("wr_bubble", 32'(out_valid), 32'd0);
      tick();
      check_head("wr_top", 32'hFFFF_FFFC);
      tick();
      check_head("wr_zero", 32'h0);
      tick();
      check_head("wr_four", 32'h4);

      // Counters: 10 pops then 2 redirects without pops
      rst_n = 1'b0;
      tick();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      tick();
      tick();
      for (int i = 0; i < 9; i++) tick();
      tick();
      out_ready      = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      tick();
      redirect_pc = 32'h200;
      tick();
      redirect_valid = 1'b0;
      check("cnt_fetch", fetch_cnt, EXP_FETCH_CNT);
      check("cnt_redir", redirect_cnt, EXP_REDIRECT_CNT);

      // Reset mid-run clears everything
      rst_n = 1'b0;
      tick();
      check("mr_valid", 32'(out_valid), 32'd0);
      check("mr_inst", out_inst, 32'd0);
      check("mr_pc", out_pc, 32'd0);
      check("mr_fcnt", fetch_cnt, 32'd0);
      check("mr_rcnt", redirect_cnt, 32'd0);
      check("mr_rompc", rom_pc, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_fetch_ctrl
